// File: rtl/rv_alu.sv
// RV32I execute-stage integer ALU: decoded opcode plus two operands in,
// result and branch/jump-taken flag out, registered with one cycle of latency.
module rv_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  alucode,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] alu_result,
    output logic        br_taken
);

    typedef enum logic [5:0] {
        ALU_LUI  = 6'd0,  ALU_JAL  = 6'd1,  ALU_JALR = 6'd2,
        ALU_BEQ  = 6'd3,  ALU_BNE  = 6'd4,  ALU_BLT  = 6'd5,
        ALU_BGE  = 6'd6,  ALU_BLTU = 6'd7,  ALU_BGEU = 6'd8,
        ALU_LB   = 6'd9,  ALU_LH   = 6'd10, ALU_LW   = 6'd11,
        ALU_LBU  = 6'd12, ALU_LHU  = 6'd13, ALU_SB   = 6'd14,
        ALU_SH   = 6'd15, ALU_SW   = 6'd16, ALU_ADD  = 6'd17,
        ALU_SUB  = 6'd18, ALU_SLT  = 6'd19, ALU_SLTU = 6'd20,
        ALU_XOR  = 6'd21, ALU_OR   = 6'd22, ALU_AND  = 6'd23,
        ALU_SLL  = 6'd24, ALU_SRL  = 6'd25, ALU_SRA  = 6'd26
    } alu_op_e;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;
    logic        eq;
    logic        lt_signed;
    logic        lt_unsigned;
    logic [31:0] result_next;
    logic        br_next;

    // Shared compare/adder terms reused across the opcode groups
    assign sum         = op1 + op2;
    assign diff        = op1 - op2;
    assign shamt       = op2[4:0];
    assign eq          = (op1 == op2);
    assign lt_signed   = ($signed(op1) < $signed(op2));
    assign lt_unsigned = (op1 < op2);

    always_comb begin
        result_next = '0;
        br_next     = 1'b0;
        case (alucode)
            ALU_LUI:  result_next = op2;
            ALU_JAL,
            ALU_JALR: begin
                result_next = op2 + 32'd4;
                br_next     = 1'b1;
            end
            ALU_BEQ:  br_next = eq;
            ALU_BNE:  br_next = !eq;
            ALU_BLT:  br_next = lt_signed;
            ALU_BGE:  br_next = !lt_signed;
            ALU_BLTU: br_next = lt_unsigned;
            ALU_BGEU: br_next = !lt_unsigned;
            ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
            ALU_SB, ALU_SH, ALU_SW,
            ALU_ADD:  result_next = sum;
            ALU_SUB:  result_next = diff;
            ALU_SLT:  result_next = {31'd0, lt_signed};
            ALU_SLTU: result_next = {31'd0, lt_unsigned};
            ALU_XOR:  result_next = op1 ^ op2;
            ALU_OR:   result_next = op1 | op2;
            ALU_AND:  result_next = op1 & op2;
            ALU_SLL:  result_next = op1 << shamt;
            ALU_SRL:  result_next = op1 >> shamt;
            ALU_SRA:  result_next = $unsigned($signed(op1) >>> shamt);
            default: begin
                result_next = '0;
                br_next     = 1'b0;
            end
        endcase
    end

    // Undefined opcodes load zero rather than holding the previous output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result <= '0;
            br_taken   <= 1'b0;
        end else begin
            alu_result <= result_next;
            br_taken   <= br_next;
        end
    end

endmodule

// File: tb/tb_rv_alu.sv
// Directed bench for rv_alu: hand-computed vectors plus a per-cycle
// comparison against an arithmetic reference model.
module tb_rv_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  alucode = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [31:0] alu_result;
    logic        br_taken;

    int checks = 0;
    int errors = 0;

    bit          model_valid = 1'b0;
    logic [31:0] model_res   = '0;
    logic        model_br    = 1'b0;

    rv_alu dut (
        .clk        (clk),
        .rst        (rst),
        .alucode    (alucode),
        .op1        (op1),
        .op2        (op2),
        .alu_result (alu_result),
        .br_taken   (br_taken)
    );

    always #5 clk = ~clk;

    // Reference: {br, result} straight from the ISA meaning of each opcode
    function automatic logic [32:0] model(input int code, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int sh;
        sa = a;
        sb = b;
        sh = b % 32;
        case (code)
            0:                  return {1'b0, b};
            1, 2:               return {1'b1, b + 32'd4};
            3:                  return {a == b, 32'd0};
            4:                  return {a != b, 32'd0};
            5:                  return {sa < sb, 32'd0};
            6:                  return {sa >= sb, 32'd0};
            7:                  return {a < b, 32'd0};
            8:                  return {a >= b, 32'd0};
            9, 10, 11, 12, 13,
            14, 15, 16, 17:     return {1'b0, a + b};
            18:                 return {1'b0, a - b};
            19:                 return {1'b0, (sa < sb) ? 32'd1 : 32'd0};
            20:                 return {1'b0, (a < b) ? 32'd1 : 32'd0};
            21:                 return {1'b0, a ^ b};
            22:                 return {1'b0, a | b};
            23:                 return {1'b0, a & b};
            24:                 return {1'b0, a << sh};
            25:                 return {1'b0, a >> sh};
            26:                 return {1'b0, 32'(sa >>> sh)};
            default:            return 33'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_valid <= 1'b0;
        end else begin
            {model_br, model_res} <= model(int'(alucode), op1, op2);
            model_valid <= 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [31:0] er;
        logic        eb;
        er = (model_valid && !rst) ? model_res : 32'd0;
        eb = (model_valid && !rst) ? model_br  : 1'b0;
        checks++;
        if (alu_result !== er || br_taken !== eb) begin
            errors++;
            $display("[TB] FAIL model t=%0t got res=%h br=%b expected res=%h br=%b",
                     $time, alu_result, br_taken, er, eb);
        end
    end

    task automatic applyStimulus(input int code, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alucode = 6'(code);
        op1     = a;
        op2     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] exp_res, input logic exp_br);
        checks++;
        if (alu_result !== exp_res || br_taken !== exp_br) begin
            errors++;
            $display("[TB] FAIL %s got res=%h br=%b expected res=%h br=%b",
                     name, alu_result, br_taken, exp_res, exp_br);
        end
    endtask

    task automatic vec(input string name, input int code, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic exp_br);
        applyStimulus(code, a, b);
        checkOutput(name, exp_res, exp_br);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2 checkOutput("reset_state", 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        vec("add",        17, 32'd34,       32'd55,       32'd89,       1'b0);
        vec("sub",        18, 32'd55,       32'd56,       32'hFFFFFFFF, 1'b0);
        vec("slt",        19, 32'hFEEDFACE, 32'hBADCAB1E, 32'd0,        1'b0);
        vec("sltu",       20, 32'hBADCAB1E, 32'hFEEDFACE, 32'd1,        1'b0);
        vec("slt_minmax", 19, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0);
        vec("xor",        21, 32'hBADCAB1E, 32'hFEEDFACE, 32'h443151D0, 1'b0);
        vec("or",         22, 32'hBADCAB1E, 32'hFEEDFACE, 32'hFEFDFBDE, 1'b0);
        vec("and",        23, 32'hBADCAB1E, 32'hFEEDFACE, 32'hBACCAA0E, 1'b0);
        vec("sll",        24, 32'hFEEDFACE, 32'd1036,     32'hDFACE000, 1'b0);
        vec("srl",        25, 32'hDEADDEAD, 32'd16,       32'h0000DEAD, 1'b0);
        vec("sra",        26, 32'hDEADDEAD, 32'd16,       32'hFFFFDEAD, 1'b0);
        vec("sra_zero",   26, 32'hDEADDEAD, 32'd32,       32'hDEADDEAD, 1'b0);
        vec("sll_zero",   24, 32'h12345678, 32'd0,        32'h12345678, 1'b0);
        vec("jal",         1, 32'hDEADBEEF, 32'h00040000, 32'h00040004, 1'b1);
        vec("jalr",        2, 32'h00000000, 32'h00050000, 32'h00050004, 1'b1);
        vec("jal_wrap",    1, 32'h00000000, 32'hFFFFFFFE, 32'h00000002, 1'b1);
        vec("beq_ne",      3, 32'hBAADF00D, 32'hBAADCAFE, 32'd0,        1'b0);
        vec("beq_eq",      3, 32'hBAADF00D, 32'hBAADF00D, 32'd0,        1'b1);
        vec("bne_eq",      4, 32'hBAADF00D, 32'hBAADF00D, 32'd0,        1'b0);
        vec("bne_ne",      4, 32'hBAADF00D, 32'hBAADCAFE, 32'd0,        1'b1);
        vec("blt_pos",     5, 32'h00000100, 32'h00000123, 32'd0,        1'b1);
        vec("blt_neg",     5, 32'h00000100, 32'hFEE1DEAD, 32'd0,        1'b0);
        vec("bge_pos",     6, 32'h00000100, 32'h00000123, 32'd0,        1'b0);
        vec("bge_neg",     6, 32'h00000100, 32'hFEE1DEAD, 32'd0,        1'b1);
        vec("bltu_lo",     7, 32'h00000100, 32'hFEE1DEAD, 32'd0,        1'b1);
        vec("bltu_hi",     7, 32'hFFFFFFFF, 32'hFEE1DEAD, 32'd0,        1'b0);
        vec("bgeu_lo",     8, 32'h00000100, 32'hFEE1DEAD, 32'd0,        1'b0);
        vec("bgeu_hi",     8, 32'hFFFFFFFF, 32'hFEE1DEAD, 32'd0,        1'b1);
        vec("lb",          9, 32'd1,        32'd1,        32'd2,        1'b0);
        vec("sw",         16, 32'd21,       32'd34,       32'd55,       1'b0);
        vec("lui",         0, 32'hFFFFFFFF, 32'd5054464,  32'd5054464,  1'b0);
        vec("add_pre",    17, 32'd34,       32'd55,       32'd89,       1'b0);
        vec("undef40",    40, 32'd34,       32'd55,       32'd0,        1'b0);
        vec("jal_pre",     1, 32'd0,        32'd8,        32'd12,       1'b1);
        vec("undef63",    63, 32'd7,        32'd9,        32'd0,        1'b0);

        // Mid-stream reset: outputs clear between edges and stay clear
        vec("rst_add1",   17, 32'd34,       32'd55,       32'd89,       1'b0);
        vec("rst_add2",   17, 32'd34,       32'd55,       32'd89,       1'b0);
        #2 rst = 1'b1;
        #1 checkOutput("rst_async", 32'd0, 1'b0);
        @(posedge clk);
        #1 checkOutput("rst_hold", 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 checkOutput("rst_release", 32'd0, 1'b0);
        @(posedge clk);
        #1 checkOutput("rst_resume", 32'd89, 1'b0);

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
